// File: rtl/regbank_burst.sv
// -----------------------------------------------------------------------------
// regbank_burst
//
// Register bank with two registered read ports and a single burst write
// port. A burst is opened with wr_start, carrying a start address and a
// length (beats minus one). The beats then stream in with a valid/ready
// handshake. The write pointer wraps modulo DEPTH. Holding read_write high
// pauses the burst without losing its place.
//
// Parameters
//   DATA_W  register/data width in bits
//   DEPTH   number of registers (power of two, >= 2)
//   LEN_W   width of the burst-length field
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   read_write         0 = writes allowed, 1 = burst paused
//   wr_start           burst start request (honoured only in IDLE)
//   wr_addr, wr_len    burst start address and beats-minus-one
//   wr_valid, hrdatax1 write beat valid and data
//   wr_ready           beat accepted this cycle when high with wr_valid
//   wr_busy            burst in progress
//   wr_done            one-cycle pulse after the final beat
//   sr1, sr2           read addresses
//   rdata1, rdata2     registered read data (one-cycle latency)
//
// Configuration macro
//   REGBANK_BYPASS_EN  when defined, a read of the address being written in
//                      the same cycle returns the new beat (write-through).
//                      When undefined, the read returns the old contents.
// -----------------------------------------------------------------------------
module regbank_burst #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       read_write,
   input  logic                       wr_start,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [LEN_W-1:0]           wr_len,
   input  logic                       wr_valid,
   input  logic [DATA_W-1:0]          hrdatax1,
   output logic                       wr_ready,
   output logic                       wr_busy,
   output logic                       wr_done,
   input  logic [$clog2(DEPTH)-1:0]   sr1,
   input  logic [$clog2(DEPTH)-1:0]   sr2,
   output logic [DATA_W-1:0]          rdata1,
   output logic [DATA_W-1:0]          rdata2
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state_q;
   logic [AW-1:0]       ptr_q;
   logic [LEN_W-1:0]    cnt_q;
   logic                busy_q;
   logic                done_q;
   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   rdata1_q, rdata2_q;
   logic [DATA_W-1:0]   rdata1_d, rdata2_d;
   logic                beatAccept;

   // wr_ready must respond in the same cycle that read_write changes, so it
   // is decoded directly from the state instead of being registered.
   assign wr_ready   = (state_q == BURST) && !read_write;
   assign beatAccept = wr_ready && wr_valid;

   assign wr_busy = busy_q;
   assign wr_done = done_q;
   assign rdata1  = rdata1_q;
   assign rdata2  = rdata2_q;

   // Burst control FSM. ptr/cnt are loaded on the start cycle and advance
   // only on accepted beats. A stall therefore holds them. busy/done are
   // registered alongside the state so they change on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_start && !read_write) begin
                  ptr_q   <= wr_addr;
                  cnt_q   <= wr_len;
                  state_q <= BURST;
                  busy_q  <= 1'b1;
               end
            end
            BURST: begin
               if (beatAccept) begin
                  ptr_q <= ptr_q + AW'(1);
                  if (cnt_q == '0) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - LEN_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Storage array. Reset clears every register, including any a burst has
   // already written. This means an abandoned burst leaves no partial data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (beatAccept) begin
         regs_q[ptr_q] <= hrdatax1;
      end
   end

   // Read-port next values. With write-through enabled, a read that hits the
   // beat being written this cycle is forwarded from the write data.
   always_comb begin
      rdata1_d = regs_q[sr1];
      rdata2_d = regs_q[sr2];
`ifdef REGBANK_BYPASS_EN
      if (beatAccept && (sr1 == ptr_q)) begin
         rdata1_d = hrdatax1;
      end
      if (beatAccept && (sr2 == ptr_q)) begin
         rdata2_d = hrdatax1;
      end
`else
      rdata1_d = regs_q[sr1];
      rdata2_d = regs_q[sr2];
`endif
   end

   // Registered read ports. These update every cycle regardless of the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

endmodule

// File: tb/tb_regbank_burst.sv
// -----------------------------------------------------------------------------
// tb_regbank_burst
//
// Testbench for regbank_burst (DATA_W=32, DEPTH=16, LEN_W=4). It runs
// directed scenarios followed by randomized traffic. The result is compared
// against a reference model. That model keeps an array of register contents
// and a queue of outstanding burst target addresses.
// -----------------------------------------------------------------------------
module tb_regbank_burst;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int LEN_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              read_write;
   logic              wr_start;
   logic [3:0]        wr_addr;
   logic [LEN_W-1:0]  wr_len;
   logic              wr_valid;
   logic [31:0]       hrdatax1;
   logic              wr_ready;
   logic              wr_busy;
   logic              wr_done;
   logic [3:0]        sr1, sr2;
   logic [31:0]       rdata1, rdata2;

   int vecCount = 0;
   int errCount = 0;

   // Reference model: register contents, plus the addresses still owed by
   // the open burst. A burst is in progress while the queue is non-empty.
   logic [31:0] refMem [DEPTH];
   int          pendAddr [$];

   regbank_burst #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .read_write (read_write),
      .wr_start   (wr_start),
      .wr_addr    (wr_addr),
      .wr_len     (wr_len),
      .wr_valid   (wr_valid),
      .hrdatax1   (hrdatax1),
      .wr_ready   (wr_ready),
      .wr_busy    (wr_busy),
      .wr_done    (wr_done),
      .sr1        (sr1),
      .sr2        (sr2),
      .rdata1     (rdata1),
      .rdata2     (rdata2)
   );

   always #5 clk = ~clk;

   // Single comparison point: count it and report a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      pendAddr.delete();
   endtask

   // Drive one cycle of inputs and predict the results of the next edge from
   // the model. wr_ready is checked before the edge and the registered
   // outputs just after it.
   task automatic applyStimulus(input bit start, input logic [3:0] addr, input logic [3:0] len,
                                input bit rw, input bit valid, input logic [31:0] data,
                                input logic [3:0] s1, input logic [3:0] s2);
      bit          busyNow, readyExp, acceptExp, doneExp;
      logic [31:0] rd1Exp, rd2Exp;
      int          wa;
      @(negedge clk);
      wr_start   = start;
      wr_addr    = addr;
      wr_len     = len;
      read_write = rw;
      wr_valid   = valid;
      hrdatax1   = data;
      sr1        = s1;
      sr2        = s2;
      #1;
      busyNow   = (pendAddr.size() != 0);
      readyExp  = busyNow && !rw;
      acceptExp = readyExp && valid;
      wa        = busyNow ? pendAddr[0] : 0;
      doneExp   = acceptExp && (pendAddr.size() == 1);
      rd1Exp    = refMem[s1];
      rd2Exp    = refMem[s2];
`ifdef REGBANK_BYPASS_EN
      if (acceptExp && int'(s1) == wa) rd1Exp = data;
      if (acceptExp && int'(s2) == wa) rd2Exp = data;
`endif
      checkOutput("wr_ready", {31'd0, wr_ready}, {31'd0, readyExp});
      @(posedge clk);
      #1;
      if (acceptExp) begin
         refMem[wa] = data;
         void'(pendAddr.pop_front());
      end else if (!busyNow && start && !rw) begin
         for (int i = 0; i <= int'(len); i++) pendAddr.push_back((int'(addr) + i) % DEPTH);
      end
      checkOutput("rdata1", rdata1, rd1Exp);
      checkOutput("rdata2", rdata2, rd2Exp);
      checkOutput("wr_busy", {31'd0, wr_busy}, {31'd0, pendAddr.size() != 0});
      checkOutput("wr_done", {31'd0, wr_done}, {31'd0, doneExp});
   endtask

   // Idle cycle that also reads two addresses.
   task automatic idleRead(input logic [3:0] s1, input logic [3:0] s2);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 32'd0, s1, s2);
   endtask

   // Assert reset between edges and check that the outputs clear immediately.
   task automatic applyReset();
      @(negedge clk);
      wr_start = 1'b0;
      wr_valid = 1'b0;
      rst      = 1'b1;
      #1;
      checkOutput("rst_rdata1", rdata1, 32'd0);
      checkOutput("rst_rdata2", rdata2, 32'd0);
      checkOutput("rst_busy", {31'd0, wr_busy}, 32'd0);
      checkOutput("rst_done", {31'd0, wr_done}, 32'd0);
      checkOutput("rst_ready", {31'd0, wr_ready}, 32'd0);
      clearModel();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] oldVal;
      rst = 1'b1; read_write = 1'b0; wr_start = 1'b0; wr_addr = '0; wr_len = '0;
      wr_valid = 1'b0; hrdatax1 = '0; sr1 = '0; sr2 = '0;
      clearModel();
      #2;
      checkOutput("init_busy", {31'd0, wr_busy}, 32'd0);
      checkOutput("init_rdata1", rdata1, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single-beat write at address 3.
      applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 32'd0, 4'd3, 4'd3);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hDEADBEEF, 4'd0, 4'd0);
      checkOutput("single_done", {31'd0, wr_done}, 32'd1);
      idleRead(4'd3, 4'd3);
      checkOutput("single_rd1", rdata1, 32'hDEADBEEF);
      checkOutput("single_done_off", {31'd0, wr_done}, 32'd0);

      // Burst wrapping from 14 to 1.
      applyStimulus(1'b1, 4'd14, 4'd3, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hA0 + i, 4'd0, 4'd0);
      idleRead(4'd14, 4'd15);
      idleRead(4'd0, 4'd1);
      checkOutput("wrap_r0", rdata1, 32'hA2);
      checkOutput("wrap_r1", rdata2, 32'hA3);

      // Four-beat burst at 6, stalled for 3 cycles after the 2nd beat. It
      // also tries an ignored start and offers data while stalled.
      applyStimulus(1'b1, 4'd6, 4'd3, 1'b0, 1'b0, 32'd0, 4'd6, 4'd7);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hB0, 4'd6, 4'd7);
      applyStimulus(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 32'hB1, 4'd6, 4'd7);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 32'hBAD0 + i, 4'd8, 4'd9);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hB2, 4'd8, 4'd9);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hB3, 4'd8, 4'd9);
      idleRead(4'd8, 4'd9);
      checkOutput("stall_r8", rdata1, 32'hB2);
      checkOutput("stall_r9", rdata2, 32'hB3);

      // Start with read_write=1 in IDLE is ignored.
      applyStimulus(1'b1, 4'd0, 4'd2, 1'b1, 1'b1, 32'h1234, 4'd0, 4'd0);
      checkOutput("ign_busy", {31'd0, wr_busy}, 32'd0);

      // Same-cycle read of the address being written.
      applyStimulus(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 32'd0, 4'd5, 4'd5);
      oldVal = refMem[5];
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'h55, 4'd5, 4'd5);
`ifdef REGBANK_BYPASS_EN
      checkOutput("bypass_rd", rdata1, 32'h55);
`else
      checkOutput("nobypass_rd", rdata1, oldVal);
`endif
      idleRead(4'd5, 4'd5);
      checkOutput("bypass_next", rdata1, 32'h55);

      // Reset after 2 of 4 beats, then a fresh burst.
      applyStimulus(1'b1, 4'd10, 4'd3, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hC0, 4'd0, 4'd0);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hC1, 4'd0, 4'd0);
      applyReset();
      idleRead(4'd10, 4'd11);
      checkOutput("rst_cleared", rdata1, 32'd0);
      applyStimulus(1'b1, 4'd10, 4'd1, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0);
      checkOutput("restart_busy", {31'd0, wr_busy}, 32'd1);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hD0, 4'd0, 4'd0);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 32'hD1, 4'd0, 4'd0);
      idleRead(4'd10, 4'd11);

      // Randomized traffic, with occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            applyReset();
         end else begin
            applyStimulus($urandom_range(0, 5) == 0, 4'($urandom), 4'($urandom),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                          $urandom, 4'($urandom), 4'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
